// File: rtl/step_sequencer_pkg.sv
// Shared constants and state encoding for the step sequencer and its pattern store.
package step_sequencer_pkg;

    localparam int NSTEPS   = 16;
    localparam int TICK_W   = 24;
    localparam int NOTE_W   = 8;
    localparam int REST_BIT = NOTE_W;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern register file: one synchronous write port, one combinational read port.
// Reset fills every entry with a rest so an unprogrammed pattern stays silent.
module seq_pattern_ram #(
    parameter int NSTEPS = 16,
    parameter int WIDTH  = 9
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NSTEPS)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic [$clog2(NSTEPS)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]          rd_data_o
);

    localparam logic [WIDTH-1:0] REST_WORD = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mem_q [NSTEPS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSTEPS; i++) begin
                mem_q[i] <= REST_WORD;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A same-cycle read of the entry being written sees the old contents.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer: walks a programmable note pattern at a tick-based tempo
// and drives the synth gate (trig) and oscillator half-period (osc_count).
module step_sequencer #(
    parameter int NSTEPS = step_sequencer_pkg::NSTEPS,
    parameter int TICK_W = step_sequencer_pkg::TICK_W,
    parameter int NOTE_W = step_sequencer_pkg::NOTE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic [$clog2(NSTEPS)-1:0] seq_len,
    input  logic [TICK_W-1:0]         tempo_div,
    input  logic [TICK_W-1:0]         gate_len,
    input  logic                      wr_en,
    input  logic [$clog2(NSTEPS)-1:0] wr_addr,
    input  logic [NOTE_W:0]           wr_data,
    output logic                      trig,
    output logic [NOTE_W-1:0]         osc_count,
    output logic [$clog2(NSTEPS)-1:0] step,
    output logic                      step_strobe,
    output logic                      busy
);

    import step_sequencer_pkg::*;

    localparam int STEP_W = $clog2(NSTEPS);

    seq_state_e          state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [STEP_W-1:0]   step_q;
    logic [NOTE_W-1:0]   osc_q;
    logic                rest_q;
    logic                trig_q;
    logic                strobe_q;
    logic                busy_q;

    logic [TICK_W-1:0]   tickLast;
    logic [TICK_W-1:0]   gateTicks;
    logic [TICK_W-1:0]   tickInc;
    logic                atStepEnd;
    logic [STEP_W-1:0]   step_d;
    logic [STEP_W-1:0]   rdAddr;
    logic [NOTE_W:0]     rdData;
    logic                rdRest;

    seq_pattern_ram #(
        .NSTEPS (NSTEPS),
        .WIDTH  (NOTE_W + 1)
    ) u_pattern (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rdAddr),
        .rd_data_o (rdData)
    );

    // Gate is capped at T-1 so trig always drops for at least one cycle per step.
    always_comb begin
        tickLast  = (tempo_div < TICK_W'(2)) ? TICK_W'(1) : (tempo_div - TICK_W'(1));
        gateTicks = (gate_len < tickLast) ? gate_len : tickLast;
        tickInc   = tick_q + TICK_W'(1);
        atStepEnd = (tick_q >= tickLast);
        step_d    = (step_q >= seq_len) ? '0 : (step_q + STEP_W'(1));
        rdAddr    = (state_q == PLAY) ? step_d : '0;
        rdRest    = rdData[NOTE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            step_q   <= '0;
            osc_q    <= '0;
            rest_q   <= 1'b0;
            trig_q   <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    strobe_q <= 1'b0;
                    trig_q   <= 1'b0;
                    if (run) begin
                        state_q  <= PLAY;
                        step_q   <= '0;
                        tick_q   <= '0;
                        strobe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        osc_q    <= rdData[NOTE_W-1:0];
                        rest_q   <= rdRest;
                        trig_q   <= (gateTicks != '0) && !rdRest;
                    end
                end
                PLAY: begin
                    if (!run) begin
                        state_q  <= IDLE;
                        trig_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        step_q   <= '0;
                        tick_q   <= '0;
                        strobe_q <= 1'b0;
                    end else if (atStepEnd) begin
                        // Note and rest flag are only sampled here, at the start of a step.
                        step_q   <= step_d;
                        tick_q   <= '0;
                        strobe_q <= 1'b1;
                        osc_q    <= rdData[NOTE_W-1:0];
                        rest_q   <= rdRest;
                        trig_q   <= (gateTicks != '0) && !rdRest;
                    end else begin
                        tick_q   <= tickInc;
                        strobe_q <= 1'b0;
                        trig_q   <= (tickInc < gateTicks) && !rest_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trig        = trig_q;
    assign osc_count   = osc_q;
    assign step        = step_q;
    assign step_strobe = strobe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: tests push expected per-step records,
// a monitor pops one on every step_strobe and checks note, step, gate and length.
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  seq_len;
    logic [23:0] tempo_div;
    logic [23:0] gate_len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        trig;
    logic [7:0]  osc_count;
    logic [3:0]  step;
    logic        step_strobe;
    logic        busy;

    typedef struct {
        int stepIdx;
        int osc;
        int trigCycles;
        int lenCycles;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   checks = 0;
    int   passes = 0;
    bit   monOn = 1'b0;
    bit   open = 1'b0;
    int   trigCnt = 0;
    int   cycCnt = 0;

    step_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .seq_len     (seq_len),
        .tempo_div   (tempo_div),
        .gate_len    (gate_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .trig        (trig),
        .osc_count   (osc_count),
        .step        (step),
        .step_strobe (step_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: closes the open step on each strobe, then opens the next expected one.
    always @(posedge clk) begin
        #1;
        if (monOn) begin
            if (busy === 1'b1 && step_strobe === 1'b1) begin
                if (open) begin
                    checks++;
                    if (trigCnt != cur.trigCycles)
                        $display("[TB] FAIL trig_cycles step %0d: got %0d expected %0d", cur.stepIdx, trigCnt, cur.trigCycles);
                    else passes++;
                    checks++;
                    if (cycCnt != cur.lenCycles)
                        $display("[TB] FAIL step_length step %0d: got %0d expected %0d", cur.stepIdx, cycCnt, cur.lenCycles);
                    else passes++;
                end
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_step: got step %0d with no expectation queued", step);
                    open = 1'b0;
                end else begin
                    cur = expQ.pop_front();
                    checks++;
                    if (step !== 4'(cur.stepIdx))
                        $display("[TB] FAIL step_index: got %0d expected %0d", step, cur.stepIdx);
                    else passes++;
                    checks++;
                    if (osc_count !== 8'(cur.osc))
                        $display("[TB] FAIL osc_count step %0d: got %0d expected %0d", cur.stepIdx, osc_count, cur.osc);
                    else passes++;
                    open    = 1'b1;
                    trigCnt = 0;
                    cycCnt  = 0;
                end
            end
            if (open) begin
                cycCnt++;
                if (trig === 1'b1) trigCnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushStep(input int s, input int o, input int tc, input int len);
        exp_t e;
        e.stepIdx    = s;
        e.osc        = o;
        e.trigCycles = tc;
        e.lenCycles  = len;
        expQ.push_back(e);
    endtask

    task automatic writeEntry(input int addr, input bit rest, input int val);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = {rest, 8'(val)};
        cycles(1);
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
    endtask

    task automatic stopPlay();
        monOn = 1'b0;
        open  = 1'b0;
        run   = 1'b0;
        cycles(2);
        expQ.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        cycles(3);
        checks++; if (trig !== 1'b0) $display("[TB] FAIL reset_trig: got %b expected 0", trig); else passes++;
        checks++; if (osc_count !== 8'd0) $display("[TB] FAIL reset_osc: got %0d expected 0", osc_count); else passes++;
        checks++; if (step !== 4'd0) $display("[TB] FAIL reset_step: got %0d expected 0", step); else passes++;
        checks++; if (step_strobe !== 1'b0) $display("[TB] FAIL reset_strobe: got %b expected 0", step_strobe); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_basic();
        bit ok;
        writeEntry(0, 1'b0, 66);
        writeEntry(1, 1'b0, 50);
        writeEntry(2, 1'b0, 40);
        writeEntry(3, 1'b0, 33);
        seq_len   = 4'd3;
        tempo_div = 24'd10;
        gate_len  = 24'd4;
        pushStep(0, 66, 4, 10);
        pushStep(1, 50, 4, 10);
        pushStep(2, 40, 4, 10);
        pushStep(3, 33, 4, 10);
        pushStep(0, 66, 4, 10);
        pushStep(1, 50, 4, 10);
        monOn = 1'b1;
        run   = 1'b1;
        cycles(1);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL start_busy: got %b expected 1", busy); else passes++;
        checks++; if (trig !== 1'b1) $display("[TB] FAIL start_trig: got %b expected 1", trig); else passes++;
        drain(120, ok);
        checks++; if (!ok) $display("[TB] FAIL basic_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL stop_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_rest();
        bit ok;
        writeEntry(1, 1'b1, 50);
        pushStep(0, 66, 4, 10);
        pushStep(1, 50, 0, 10);
        pushStep(2, 40, 4, 10);
        pushStep(3, 33, 4, 10);
        pushStep(0, 66, 4, 10);
        monOn = 1'b1;
        run   = 1'b1;
        drain(120, ok);
        checks++; if (!ok) $display("[TB] FAIL rest_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();
        writeEntry(1, 1'b0, 50);
    endtask

    task automatic test_gate_limits();
        bit ok;
        gate_len  = 24'd20;
        tempo_div = 24'd10;
        pushStep(0, 66, 9, 10);
        pushStep(1, 50, 9, 10);
        pushStep(2, 40, 9, 10);
        pushStep(3, 33, 9, 10);
        monOn = 1'b1;
        run   = 1'b1;
        drain(100, ok);
        checks++; if (!ok) $display("[TB] FAIL long_gate_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();

        tempo_div = 24'd0;
        for (int i = 0; i < 4; i++) pushStep(i, (i == 0) ? 66 : (i == 1) ? 50 : (i == 2) ? 40 : 33, 1, 2);
        pushStep(0, 66, 1, 2);
        monOn = 1'b1;
        run   = 1'b1;
        drain(40, ok);
        checks++; if (!ok) $display("[TB] FAIL min_tempo_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();

        gate_len  = 24'd0;
        tempo_div = 24'd10;
        pushStep(0, 66, 0, 10);
        pushStep(1, 50, 0, 10);
        pushStep(2, 40, 0, 10);
        monOn = 1'b1;
        run   = 1'b1;
        drain(60, ok);
        checks++; if (!ok) $display("[TB] FAIL zero_gate_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();
        gate_len = 24'd4;
    endtask

    task automatic test_run_restart();
        bit found = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            cycles(1);
            if (step === 4'd2 && step_strobe === 1'b1) found = 1'b1;
        end
        checks++; if (!found) $display("[TB] FAIL reach_step2: got step %0d expected 2", step); else passes++;
        cycles(5);
        run = 1'b0;
        cycles(1);
        checks++; if (trig !== 1'b0) $display("[TB] FAIL stop_trig: got %b expected 0", trig); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL stop_busy2: got %b expected 0", busy); else passes++;
        checks++; if (step !== 4'd0) $display("[TB] FAIL stop_step: got %0d expected 0", step); else passes++;
        checks++; if (osc_count !== 8'd40) $display("[TB] FAIL stop_osc_hold: got %0d expected 40", osc_count); else passes++;
        run = 1'b1;
        cycles(1);
        checks++; if (step !== 4'd0) $display("[TB] FAIL restart_step: got %0d expected 0", step); else passes++;
        checks++; if (osc_count !== 8'd66) $display("[TB] FAIL restart_osc: got %0d expected 66", osc_count); else passes++;
        checks++; if (step_strobe !== 1'b1) $display("[TB] FAIL restart_strobe: got %b expected 1", step_strobe); else passes++;
        stopPlay();
    endtask

    task automatic test_live_write();
        bit ok;
        bit found = 1'b0;
        pushStep(0, 66, 4, 10);
        pushStep(1, 50, 4, 10);
        pushStep(2, 40, 4, 10);
        pushStep(3, 33, 4, 10);
        pushStep(0, 66, 4, 10);
        pushStep(1, 50, 4, 10);
        pushStep(2, 99, 4, 10);
        pushStep(3, 33, 4, 10);
        monOn = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            cycles(1);
            if (step === 4'd2 && step_strobe === 1'b1) found = 1'b1;
        end
        checks++; if (!found) $display("[TB] FAIL live_reach_step2: got step %0d expected 2", step); else passes++;
        writeEntry(2, 1'b0, 99);
        checks++; if (osc_count !== 8'd40) $display("[TB] FAIL live_osc_hold: got %0d expected 40", osc_count); else passes++;
        drain(120, ok);
        checks++; if (!ok) $display("[TB] FAIL live_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();
        writeEntry(2, 1'b0, 40);
    endtask

    task automatic test_write_collision();
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = {1'b0, 8'd11};
        run     = 1'b1;
        cycles(1);
        wr_en = 1'b0;
        checks++; if (osc_count !== 8'd66) $display("[TB] FAIL collide_old_data: got %0d expected 66", osc_count); else passes++;
        stopPlay();
        run = 1'b1;
        cycles(1);
        checks++; if (osc_count !== 8'd11) $display("[TB] FAIL collide_new_data: got %0d expected 11", osc_count); else passes++;
        stopPlay();
        writeEntry(0, 1'b0, 66);
    endtask

    task automatic test_reset_mid_play();
        bit ok;
        run = 1'b1;
        cycles(13);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = {1'b0, 8'd77};
        cycles(1);
        checks++; if (trig !== 1'b0) $display("[TB] FAIL midrst_trig: got %b expected 0", trig); else passes++;
        checks++; if (osc_count !== 8'd0) $display("[TB] FAIL midrst_osc: got %0d expected 0", osc_count); else passes++;
        checks++; if (step !== 4'd0) $display("[TB] FAIL midrst_step: got %0d expected 0", step); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passes++;
        rst   = 1'b0;
        wr_en = 1'b0;
        pushStep(0, 0, 0, 10);
        pushStep(1, 0, 0, 10);
        pushStep(2, 0, 0, 10);
        pushStep(3, 0, 0, 10);
        pushStep(0, 0, 0, 10);
        monOn = 1'b1;
        drain(120, ok);
        checks++; if (!ok) $display("[TB] FAIL midrst_timeout: got %0d pending expected 0", expQ.size()); else passes++;
        stopPlay();
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        seq_len   = 4'd3;
        tempo_div = 24'd10;
        gate_len  = 24'd4;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 9'd0;
        test_reset();
        test_basic();
        test_rest();
        test_gate_limits();
        test_run_restart();
        test_live_write();
        test_write_collision();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
